highscore_keeper: RTL and testbench

Consumes the finished score from the points stage at end of game. Converts it to packed BCD for the endgame screen and keeps a best-score record per difficulty level. Sits directly downstream of the points calculator (its `points` / `points_calculated` outputs) and upstream of the endgame screen text renderer.

---
 rtl/highscore_keeper_pkg.sv | 35 +++
 rtl/highscore_keeper_bin2bcd_seq.sv | 77 +++++++
 rtl/highscore_keeper.sv | 139 +++++++++++++
 tb/tb_highscore_keeper.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/highscore_keeper_pkg.sv
// rtl/highscore_keeper_pkg.sv - shared widths, level codes and FSM encodings for highscore_keeper
package highscore_keeper_pkg;

    localparam int HK_SCORE_W        = 14;
    localparam int HK_BCD_DIGITS     = 5;
    localparam int CARD_MAX_NUM_SIZE = 2;
    localparam int NUM_LEVELS        = 3;

    // num_of_cards codes coming from the game setup
    localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_EASY   = 2'd0;
    localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_NORMAL = 2'd1;
    localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_HARD   = 2'd2;

    // record-table indices; LVL_NONE marks a level with no record slot
    localparam logic [1:0] LVL_EASY   = 2'd0;
    localparam logic [1:0] LVL_NORMAL = 2'd1;
    localparam logic [1:0] LVL_HARD   = 2'd2;
    localparam logic [1:0] LVL_NONE   = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;

    function automatic logic [1:0] decode_level(input logic [CARD_MAX_NUM_SIZE-1:0] n);
        logic [1:0] lvl;
        case (n)
            CARD_NUM_EASY:   lvl = LVL_EASY;
            CARD_NUM_NORMAL: lvl = LVL_NORMAL;
            CARD_NUM_HARD:   lvl = LVL_HARD;
            default:         lvl = LVL_NONE;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/highscore_keeper_bin2bcd_seq.sv
// rtl/highscore_keeper_bin2bcd_seq.sv - iterative double-dabble converter, one bit per cycle
module bin2bcd_seq
    import highscore_keeper_pkg::*;
#(
    parameter int W      = HK_SCORE_W,
    parameter int DIGITS = HK_BCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W-1:0]        bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(W);

    logic [W-1:0]     bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [BW-1:0]    adj;
    logic [BW+W-1:0]  shifted;

    // One iteration: add-3 correction on every nibble >= 5, then shift {bcd, bin} left
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            bcd_d = shifted[BW+W-1 -: BW];
            bin_d = shifted[W-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end else if (start) begin
            bin_d  = bin;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    // Converter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // done marks the cycle whose closing edge runs the final iteration; bcd is final after it
    assign done = busy_q && (cnt_q == CNT_W'(W - 1));
    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/highscore_keeper.sv
// rtl/highscore_keeper.sv - end-of-game score to BCD with per-level best-score records
module highscore_keeper
    import highscore_keeper_pkg::*;
#(
    parameter int SCORE_W    = HK_SCORE_W,
    parameter int BCD_DIGITS = HK_BCD_DIGITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         points_valid,
    input  logic [SCORE_W-1:0]           points,
    input  logic [CARD_MAX_NUM_SIZE-1:0] num_of_cards,
    input  logic                         clear_records,
    output logic [4*BCD_DIGITS-1:0]      score_bcd,
    output logic [4*BCD_DIGITS-1:0]      best_bcd,
    output logic                         new_record,
    output logic                         busy,
    output logic                         done
);

    localparam int BW = 4 * BCD_DIGITS;

    logic [1:0]                           state_q, state_d;
    logic [SCORE_W-1:0]                   score_q, score_d;
    logic [CARD_MAX_NUM_SIZE-1:0]         level_q, level_d;
    logic [NUM_LEVELS-1:0][SCORE_W-1:0]   best_bin_q, best_bin_d;
    logic [NUM_LEVELS-1:0][BW-1:0]        best_bcd_q, best_bcd_d;
    logic [BW-1:0]                        score_bcd_q, score_bcd_d;
    logic [BW-1:0]                        best_out_q, best_out_d;
    logic                                 new_record_q, new_record_d;
    logic                                 done_q, done_d;

    logic                                 conv_start;
    logic                                 conv_busy;
    logic                                 conv_done;
    logic [BW-1:0]                        conv_bcd;
    logic [1:0]                           lvl;

    bin2bcd_seq #(
        .W      (SCORE_W),
        .DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (points),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign lvl = decode_level(level_q);

    // FSM shell: accept a score, wait for the converter, then compare and publish
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        level_d      = level_q;
        best_bin_d   = best_bin_q;
        best_bcd_d   = best_bcd_q;
        score_bcd_d  = score_bcd_q;
        best_out_d   = best_out_q;
        new_record_d = new_record_q;
        done_d       = 1'b0;
        conv_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (points_valid) begin
                    score_d    = points;
                    level_d    = num_of_cards;
                    conv_start = 1'b1;
                    state_d    = ST_CONVERT;
                end else if (clear_records) begin
                    best_bin_d = '0;
                    best_bcd_d = '0;
                end
            end
            ST_CONVERT: begin
                // a converter that is no longer busy also ends the wait, so the FSM cannot stall
                if (conv_done || !conv_busy) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                new_record_d = 1'b0;
                best_out_d   = '0;
                for (int i = 0; i < NUM_LEVELS; i++) begin
                    if (lvl == i[1:0]) begin
                        if (score_q > best_bin_q[i]) begin
                            best_bin_d[i] = score_q;
                            best_bcd_d[i] = conv_bcd;
                            best_out_d    = conv_bcd;
                            new_record_d  = 1'b1;
                        end else begin
                            best_out_d    = best_bcd_q[i];
                        end
                    end
                end
                score_bcd_d = conv_bcd;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control, record and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            level_q      <= '0;
            best_bin_q   <= '0;
            best_bcd_q   <= '0;
            score_bcd_q  <= '0;
            best_out_q   <= '0;
            new_record_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            level_q      <= level_d;
            best_bin_q   <= best_bin_d;
            best_bcd_q   <= best_bcd_d;
            score_bcd_q  <= score_bcd_d;
            best_out_q   <= best_out_d;
            new_record_q <= new_record_d;
            done_q       <= done_d;
        end
    end

    assign score_bcd  = score_bcd_q;
    assign best_bcd   = best_out_q;
    assign new_record = new_record_q;
    assign done       = done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_highscore_keeper.sv
// tb/tb_highscore_keeper.sv - directed self-checking bench for highscore_keeper
module tb_highscore_keeper;

    logic        clk;
    logic        rst;
    logic        points_valid;
    logic [13:0] points;
    logic [1:0]  num_of_cards;
    logic        clear_records;
    logic [19:0] score_bcd;
    logic [19:0] best_bcd;
    logic        new_record;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    highscore_keeper dut (
        .clk           (clk),
        .rst           (rst),
        .points_valid  (points_valid),
        .points        (points),
        .num_of_cards  (num_of_cards),
        .clear_records (clear_records),
        .score_bcd     (score_bcd),
        .best_bcd      (best_bcd),
        .new_record    (new_record),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_game(input logic [13:0] p, input logic [1:0] lv, output int lat);
        @(negedge clk);
        points       = p;
        num_of_cards = lv;
        points_valid = 1'b1;
        @(posedge clk);
        #1 points_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (score_bcd !== 20'h0) begin errors++; $display("FAIL reset_score got %h want 00000", score_bcd); end
        checks++; if (best_bcd !== 20'h0) begin errors++; $display("FAIL reset_best got %h want 00000", best_bcd); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL reset_new_record got %b want 0", new_record); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_easy();
        int lat;
        run_game(14'd9966, 2'd0, lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL easy1_latency got %0d want 15", lat); end
        checks++; if (score_bcd !== 20'h09966) begin errors++; $display("FAIL easy1_score got %h want 09966", score_bcd); end
        checks++; if (best_bcd !== 20'h09966) begin errors++; $display("FAIL easy1_best got %h want 09966", best_bcd); end
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL easy1_record got %b want 1", new_record); end
        run_game(14'd5000, 2'd0, lat);
        checks++; if (score_bcd !== 20'h05000) begin errors++; $display("FAIL easy2_score got %h want 05000", score_bcd); end
        checks++; if (best_bcd !== 20'h09966) begin errors++; $display("FAIL easy2_best got %h want 09966", best_bcd); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL easy2_record got %b want 0", new_record); end
        run_game(14'd9966, 2'd0, lat);
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL easy_tie_record got %b want 0", new_record); end
        checks++; if (best_bcd !== 20'h09966) begin errors++; $display("FAIL easy_tie_best got %h want 09966", best_bcd); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
        checks++; if (score_bcd !== 20'h09966) begin errors++; $display("FAIL hold_score got %h want 09966", score_bcd); end
    endtask

    task automatic test_levels();
        int lat;
        run_game(14'd1234, 2'd1, lat);
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL normal_record got %b want 1", new_record); end
        checks++; if (best_bcd !== 20'h01234) begin errors++; $display("FAIL normal_best got %h want 01234", best_bcd); end
        run_game(14'd1, 2'd0, lat);
        checks++; if (best_bcd !== 20'h09966) begin errors++; $display("FAIL iso_easy_best got %h want 09966", best_bcd); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL iso_easy_record got %b want 0", new_record); end
        checks++; if (score_bcd !== 20'h00001) begin errors++; $display("FAIL iso_easy_score got %h want 00001", score_bcd); end
    endtask

    task automatic test_range_busy();
        int done_cnt;
        int done_edge;
        int lat;
        done_cnt  = 0;
        done_edge = 0;
        @(negedge clk);
        points       = 14'd16383;
        num_of_cards = 2'd2;
        points_valid = 1'b1;
        @(posedge clk);
        #1 points_valid = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %b want 1", busy); end
            end
            if (done) begin
                done_cnt++;
                done_edge = e;
            end
            if (e == 4) begin
                points       = 14'd7;
                num_of_cards = 2'd0;
                points_valid = 1'b1;
            end
            if (e == 5) points_valid = 1'b0;
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
        checks++; if (done_edge !== 15) begin errors++; $display("FAIL busy_done_edge got %0d want 15", done_edge); end
        checks++; if (score_bcd !== 20'h16383) begin errors++; $display("FAIL max_score got %h want 16383", score_bcd); end
        checks++; if (best_bcd !== 20'h16383) begin errors++; $display("FAIL max_best got %h want 16383", best_bcd); end
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL max_record got %b want 1", new_record); end
        points       = 14'd42;
        num_of_cards = 2'd0;
        points_valid = 1'b1;
        @(posedge clk);
        #1 points_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL n16_accept_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL n16_done_low got %b want 0", done); end
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 15) begin errors++; $display("FAIL n16_latency got %0d want 15", lat); end
        checks++; if (score_bcd !== 20'h00042) begin errors++; $display("FAIL n16_score got %h want 00042", score_bcd); end
        checks++; if (best_bcd !== 20'h09966) begin errors++; $display("FAIL n16_best got %h want 09966", best_bcd); end
    endtask

    task automatic test_clear_invalid();
        int lat;
        @(negedge clk);
        clear_records = 1'b1;
        @(negedge clk);
        clear_records = 1'b0;
        run_game(14'd1, 2'd0, lat);
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL clear_easy_record got %b want 1", new_record); end
        checks++; if (best_bcd !== 20'h00001) begin errors++; $display("FAIL clear_easy_best got %h want 00001", best_bcd); end
        run_game(14'd500, 2'd3, lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL invalid_latency got %0d want 15", lat); end
        checks++; if (score_bcd !== 20'h00500) begin errors++; $display("FAIL invalid_score got %h want 00500", score_bcd); end
        checks++; if (best_bcd !== 20'h0) begin errors++; $display("FAIL invalid_best got %h want 00000", best_bcd); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL invalid_record got %b want 0", new_record); end
        run_game(14'd3, 2'd2, lat);
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL clear_hard_record got %b want 1", new_record); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        int lat;
        done_cnt = 0;
        @(negedge clk);
        points       = 14'd77;
        num_of_cards = 2'd0;
        points_valid = 1'b1;
        @(posedge clk);
        #1 points_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (score_bcd !== 20'h0) begin errors++; $display("FAIL midrst_score got %h want 00000", score_bcd); end
        checks++; if (best_bcd !== 20'h0) begin errors++; $display("FAIL midrst_best got %h want 00000", best_bcd); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL midrst_record got %b want 0", new_record); end
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", done_cnt); end
        run_game(14'd1, 2'd0, lat);
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL midrst_easy_record got %b want 1", new_record); end
        run_game(14'd1, 2'd1, lat);
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL midrst_normal_record got %b want 1", new_record); end
        checks++; if (best_bcd !== 20'h00001) begin errors++; $display("FAIL midrst_normal_best got %h want 00001", best_bcd); end
    endtask

    initial begin
        rst           = 1'b1;
        points_valid  = 1'b0;
        points        = '0;
        num_of_cards  = '0;
        clear_records = 1'b0;
        test_reset();
        test_easy();
        test_levels();
        test_range_busy();
        test_clear_invalid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
